// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding and qualifier width.
package run_ctrl_pkg;

    localparam int QW = 3;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        REQ,
        RUN,
        FIN
    } run_state_t;

endpackage

// File: rtl/run_ctrl_if.sv
// Control/status bundle between a run launcher (master) and run_ctrl (slave).
interface run_ctrl_if #(
    parameter int CW = 16
);
    logic          start;
    logic          abort;
    logic          cpu_done;
    logic          cpu_reset;
    logic          cpu_req;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycles;

    modport master (
        output start, abort, cpu_done,
        input  cpu_reset, cpu_req, busy, finished, timed_out, cycles
    );

    modport slave (
        input  start, abort, cpu_done,
        output cpu_reset, cpu_req, busy, finished, timed_out, cycles
    );
endinterface

// File: rtl/run_ctrl_done_filter.sv
// Consecutive-high qualifier for cpu_done; 'qualified' is combinational on the
// current done so the FSM can leave RUN on the DONE_QUAL-th high cycle.
module done_filter
    import run_ctrl_pkg::*;
#(
    parameter int DONE_QUAL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic done,
    output logic qualified
);
    localparam logic [QW-1:0] QMAX = '1;
    localparam logic [QW-1:0] QTHR = QW'(DONE_QUAL - 1);

    logic [QW-1:0] run_len;

    assign qualified = en && done && (run_len >= QTHR);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            run_len <= '0;
        end else if (en) begin
            if (!done)
                run_len <= '0;
            else if (run_len != QMAX)
                run_len <= run_len + 1'b1;
        end
    end
endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the CPU in reset, pulses req, times the run until a
// qualified done. Watchdog exit is built in when RUN_TIMEOUT_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          RST_CYC   = 2,
    parameter int          CW        = 16,
    parameter int          DONE_QUAL = 1,
    parameter int unsigned TIMEOUT   = 16'hFFFF
) (
    input  logic clk,
    input  logic reset,
    run_ctrl_if.slave bus
);
    run_state_t    state;
    logic [3:0]    rst_tmr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          qualified;
    logic          to_hit;

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    done_filter #(.DONE_QUAL(DONE_QUAL)) u_filter (
        .clk       (clk),
        .reset     (reset),
        .en        (state == RUN),
        .clr       (state == IDLE),
        .done      (bus.cpu_done),
        .qualified (qualified)
    );

`ifdef RUN_TIMEOUT_EN
    logic timed_out_q;

    assign to_hit = (cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset)
            timed_out_q <= 1'b0;
        else if (state == IDLE && bus.start)
            timed_out_q <= 1'b0;
        else if (state == RUN && !bus.abort && !qualified && to_hit)
            timed_out_q <= 1'b1;
    end

    assign bus.timed_out = timed_out_q;
`else
    // Watchdog compiled out; TIMEOUT has no effect in this build.
    assign to_hit        = 1'b0 & (TIMEOUT != 0);
    assign bus.timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rst_tmr <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state   <= RST;
                    rst_tmr <= 4'(RST_CYC);
                    cnt     <= '0;
                end
                RST: begin
                    rst_tmr <= rst_tmr - 1'b1;
                    if (bus.abort)
                        state <= IDLE;
                    else if (rst_tmr <= 4'd1)
                        state <= REQ;
                end
                REQ: state <= bus.abort ? IDLE : RUN;
                RUN: begin
                    // The count includes the cycle that ends the run, abort included.
                    cnt <= cnt_inc;
                    if (bus.abort)
                        state <= IDLE;
                    else if (qualified || to_hit)
                        state <= FIN;
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_reset = (state == IDLE) || (state == RST);
    assign bus.cpu_req   = (state == REQ);
    assign bus.busy      = (state != IDLE);
    assign bus.finished  = (state == FIN);
    assign bus.cycles    = cnt;
endmodule
